// File: rtl/chu_logger_pkg.sv
// Shared definitions for the sample logger slot core:
// register indices, ctrl bit positions and the FIFO entry layout.
package chu_logger_pkg;

   localparam logic [2:0] REG_STATUS    = 3'd0;
   localparam logic [2:0] REG_DATA_CTRL = 3'd1;
   localparam logic [2:0] REG_PERIOD    = 3'd2;
   localparam logic [2:0] REG_POP       = 3'd3;
   localparam logic [2:0] REG_THRESH    = 3'd4;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_MODE = 1;
   localparam int CTRL_CLR  = 2;

   typedef struct packed {
      logic [15:0] ts;
      logic [15:0] smp;
   } log_entry_t;

endpackage

// File: rtl/chu_logger_fifo.sv
// Synchronous FIFO with first-word-fall-through head, depth 2**ADDR_W.
// Clear beats push/pop; a push into a full FIFO lands only with a pop.
module chu_logger_fifo
   import chu_logger_pkg::*;
#(
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              push,
   input  logic              pop,
   input  logic [31:0]       wr_data,
   output logic [31:0]       head,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [31:0]     mem [DEPTH];
   logic [ADDR_W:0] wr_ptr;
   logic [ADDR_W:0] rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign count   = wr_ptr - rd_ptr;
   assign empty   = (count == '0);
   // count never exceeds DEPTH, so its MSB alone flags full
   assign full    = count[ADDR_W];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr[ADDR_W-1:0]];

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
   end

endmodule

// File: rtl/chu_sample_logger_core.sv
// MMIO slot core logging timestamped samples of din into a FIFO.
// Define LOGGER_IRQ_EN to add the irq output and threshold register.
module chu_sample_logger_core
   import chu_logger_pkg::*;
#(
   parameter int W              = 8,
   parameter int FIFO_DEPTH_BIT = 4,
   parameter int TS_W           = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cs,
   input  logic          read,
   input  logic          write,
   input  logic [4:0]    addr,
   output logic [31:0]   rd_data,
   input  logic [31:0]   wr_data,
   input  logic [W-1:0]  din
`ifdef LOGGER_IRQ_EN
   ,
   output logic          irq
`endif
);

   logic [W-1:0]          din_m;
   logic [W-1:0]          din_s;
   logic [W-1:0]          din_q;
   logic                  en;
   logic                  mode;
   logic [31:0]           period;
   logic [31:0]           tick_cnt;
   logic [TS_W-1:0]       ts;
   logic                  ovf;
   logic                  wr_ctrl;
   logic                  wr_period;
   logic                  wr_pop;
   logic                  wr_thresh;
   logic                  clr;
   logic                  tick;
   logic                  push;
   logic [15:0]           smp;
   log_entry_t            entry;
   logic [31:0]           head;
   logic                  full;
   logic                  empty;
   logic [FIFO_DEPTH_BIT:0] count;
   logic                  unused_bits;

`ifdef LOGGER_IRQ_EN
   logic [FIFO_DEPTH_BIT:0] thresh;
   assign unused_bits = ^{read, addr[4:3]};
`else
   assign unused_bits = ^{read, addr[4:3], wr_thresh};
`endif

   always_comb begin
      wr_ctrl   = 1'b0;
      wr_period = 1'b0;
      wr_pop    = 1'b0;
      wr_thresh = 1'b0;
      if (cs && write) begin
         unique case (addr[2:0])
            REG_DATA_CTRL: wr_ctrl   = 1'b1;
            REG_PERIOD:    wr_period = 1'b1;
            REG_POP:       wr_pop    = 1'b1;
            REG_THRESH:    wr_thresh = 1'b1;
            default:       ;
         endcase
      end
   end

   assign clr = wr_ctrl & wr_data[CTRL_CLR];

   // din_q follows din_s even while disabled, so enabling never fakes a change
   always_ff @(posedge clk) begin
      if (reset) begin
         din_m <= '0;
         din_s <= '0;
         din_q <= '0;
      end else begin
         din_m <= din;
         din_s <= din_m;
         din_q <= din_s;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         en   <= 1'b0;
         mode <= 1'b0;
      end else if (wr_ctrl) begin
         en   <= wr_data[CTRL_EN];
         mode <= wr_data[CTRL_MODE];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         period <= '0;
      end else if (wr_period) begin
         period <= wr_data;
      end
   end

   assign tick = en & (tick_cnt == period);

   always_ff @(posedge clk) begin
      if (reset) begin
         tick_cnt <= '0;
      end else if (clr || wr_period || !en || tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ts <= '0;
      end else if (clr) begin
         ts <= '0;
      end else if (en) begin
         ts <= ts + 1'b1;
      end
   end

   always_comb begin
      smp          = '0;
      smp[W-1:0]   = din_s;
      entry.ts     = ts;
      entry.smp    = smp;
   end

   assign push = en & (mode ? (din_s != din_q) : tick);

   always_ff @(posedge clk) begin
      if (reset) begin
         ovf <= 1'b0;
      end else if (clr) begin
         ovf <= 1'b0;
      end else if (push && full && !wr_pop) begin
         ovf <= 1'b1;
      end
   end

   chu_logger_fifo #(
      .ADDR_W (FIFO_DEPTH_BIT)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .clear   (clr),
      .push    (push),
      .pop     (wr_pop),
      .wr_data (entry),
      .head    (head),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

`ifdef LOGGER_IRQ_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         thresh <= '0;
      end else if (wr_thresh) begin
         thresh <= wr_data[FIFO_DEPTH_BIT:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         irq <= 1'b0;
      end else begin
         irq <= ((thresh != '0) && (count >= thresh)) || ovf;
      end
   end
`endif

   always_comb begin
      rd_data = '0;
      unique case (addr[2:0])
         REG_STATUS: begin
            rd_data[FIFO_DEPTH_BIT+16:16] = count;
            rd_data[2:0]                  = {ovf, full, empty};
         end
         REG_DATA_CTRL: begin
            if (!empty) rd_data = head;
         end
         REG_PERIOD: rd_data = period;
`ifdef LOGGER_IRQ_EN
         REG_THRESH: rd_data[FIFO_DEPTH_BIT:0] = thresh;
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_chu_sample_logger_core.sv
// Directed self-checking bench for chu_sample_logger_core.
// Expected values are hand-derived from edge-by-edge timing.
module tb_chu_sample_logger_core;

   logic        clk;
   logic        reset;
   logic        cs;
   logic        read;
   logic        write;
   logic [4:0]  addr;
   logic [31:0] rd_data;
   logic [31:0] wr_data;
   logic [7:0]  din;
`ifdef LOGGER_IRQ_EN
   logic        irq;
`endif

   int checks;
   int errors;

   chu_sample_logger_core #(
      .W              (8),
      .FIFO_DEPTH_BIT (4),
      .TS_W           (16)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .cs      (cs),
      .read    (read),
      .write   (write),
      .addr    (addr),
      .rd_data (rd_data),
      .wr_data (wr_data),
      .din     (din)
`ifdef LOGGER_IRQ_EN
      ,
      .irq     (irq)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // called at a negedge; the write lands on the next posedge
   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      cs      = 1'b1;
      write   = 1'b1;
      addr    = {2'b00, a};
      wr_data = d;
      @(negedge clk);
      cs      = 1'b0;
      write   = 1'b0;
      wr_data = '0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      cs   = 1'b1;
      read = 1'b1;
      addr = {2'b00, a};
      #1;
      d    = rd_data;
      cs   = 1'b0;
      read = 1'b0;
   endtask

   task automatic test_reset;
      logic [31:0] v;
      rd(3'd0, v);
      checks++;
      if (v !== 32'h0000_0001) begin
         errors++;
         $display("FAIL reset_status got %h exp %h", v, 32'h1);
      end
      rd(3'd1, v);
      checks++;
      if (v !== 32'h0) begin
         errors++;
         $display("FAIL reset_data got %h exp %h", v, 32'h0);
      end
      rd(3'd2, v);
      checks++;
      if (v !== 32'h0) begin
         errors++;
         $display("FAIL reset_period got %h exp %h", v, 32'h0);
      end
      rd(3'd5, v);
      checks++;
      if (v !== 32'h0) begin
         errors++;
         $display("FAIL unmapped_read got %h exp %h", v, 32'h0);
      end
   endtask

   task automatic test_periodic;
      logic [31:0] v;
      logic [15:0] prev_ts;
      wr(3'd2, 32'd9);
      rd(3'd2, v);
      checks++;
      if (v !== 32'd9) begin
         errors++;
         $display("FAIL period_rb got %h exp %h", v, 32'd9);
      end
      wr(3'd1, 32'h5);
      repeat (49) @(negedge clk);
      wr(3'd1, 32'h0);
      rd(3'd0, v);
      checks++;
      if (v !== 32'h0005_0000) begin
         errors++;
         $display("FAIL periodic_status got %h exp %h", v, 32'h0005_0000);
      end
      prev_ts = '0;
      for (int i = 0; i < 5; i++) begin
         rd(3'd1, v);
         checks++;
         if (v !== {16'(9 + 10 * i), 16'h0000}) begin
            errors++;
            $display("FAIL periodic_entry%0d got %h exp %h", i, v,
                     {16'(9 + 10 * i), 16'h0000});
         end
         if (i > 0) begin
            checks++;
            if (v[31:16] - prev_ts !== 16'd10) begin
               errors++;
               $display("FAIL periodic_delta%0d got %0d exp 10", i,
                        v[31:16] - prev_ts);
            end
         end
         prev_ts = v[31:16];
         wr(3'd3, 32'h0);
      end
      rd(3'd0, v);
      checks++;
      if (v !== 32'h0000_0001) begin
         errors++;
         $display("FAIL periodic_drained got %h exp %h", v, 32'h1);
      end
   endtask

   task automatic test_on_change;
      logic [31:0] v;
      logic [15:0] t0;
      wr(3'd1, 32'h7);
      din = 8'h5A;
      repeat (2) @(negedge clk);
      rd(3'd0, v);
      checks++;
      if (v !== 32'h0000_0001) begin
         errors++;
         $display("FAIL chg_early got %h exp %h", v, 32'h1);
      end
      @(negedge clk);
      rd(3'd0, v);
      checks++;
      if (v !== 32'h0001_0000) begin
         errors++;
         $display("FAIL chg_latency got %h exp %h", v, 32'h0001_0000);
      end
      repeat (7) @(negedge clk);
      din = 8'h5A;
      repeat (10) @(negedge clk);
      din = 8'hA5;
      repeat (5) @(negedge clk);
      wr(3'd1, 32'h0);
      rd(3'd0, v);
      checks++;
      if (v !== 32'h0002_0000) begin
         errors++;
         $display("FAIL chg_count got %h exp %h", v, 32'h0002_0000);
      end
      rd(3'd1, v);
      t0 = v[31:16];
      checks++;
      if (v !== 32'h0002_005A) begin
         errors++;
         $display("FAIL chg_entry0 got %h exp %h", v, 32'h0002_005A);
      end
      wr(3'd3, 32'h0);
      rd(3'd1, v);
      checks++;
      if (v !== 32'h0016_00A5) begin
         errors++;
         $display("FAIL chg_entry1 got %h exp %h", v, 32'h0016_00A5);
      end
      checks++;
      if (v[31:16] - t0 !== 16'd20) begin
         errors++;
         $display("FAIL chg_delta got %0d exp 20", v[31:16] - t0);
      end
      wr(3'd3, 32'h0);
   endtask

   task automatic test_overflow;
      logic [31:0] v;
      wr(3'd2, 32'd0);
      wr(3'd1, 32'h5);
      repeat (19) @(negedge clk);
      wr(3'd1, 32'h0);
      rd(3'd0, v);
      checks++;
      if (v !== 32'h0010_0006) begin
         errors++;
         $display("FAIL ovf_status got %h exp %h", v, 32'h0010_0006);
      end
      rd(3'd1, v);
      checks++;
      if (v !== 32'h0000_00A5) begin
         errors++;
         $display("FAIL ovf_head got %h exp %h", v, 32'h0000_00A5);
      end
      repeat (16) wr(3'd3, 32'h0);
      rd(3'd0, v);
      checks++;
      if (v !== 32'h0000_0005) begin
         errors++;
         $display("FAIL ovf_sticky got %h exp %h", v, 32'h5);
      end
      wr(3'd1, 32'h4);
      rd(3'd0, v);
      checks++;
      if (v !== 32'h0000_0001) begin
         errors++;
         $display("FAIL ovf_clear got %h exp %h", v, 32'h1);
      end
      wr(3'd1, 32'h1);
      wr(3'd1, 32'h0);
      rd(3'd1, v);
      checks++;
      if (v !== 32'h0000_00A5) begin
         errors++;
         $display("FAIL clear_ts got %h exp %h", v, 32'h0000_00A5);
      end
      wr(3'd3, 32'h0);
   endtask

   task automatic test_full_push_pop;
      logic [31:0] v;
      wr(3'd1, 32'h4);
      wr(3'd2, 32'd0);
      wr(3'd1, 32'h1);
      repeat (15) @(negedge clk);
      wr(3'd1, 32'h0);
      rd(3'd0, v);
      checks++;
      if (v !== 32'h0010_0002) begin
         errors++;
         $display("FAIL fpp_fill got %h exp %h", v, 32'h0010_0002);
      end
      wr(3'd2, 32'd9);
      wr(3'd1, 32'h1);
      repeat (9) @(negedge clk);
      wr(3'd3, 32'h0);
      wr(3'd1, 32'h0);
      rd(3'd0, v);
      checks++;
      if (v !== 32'h0010_0002) begin
         errors++;
         $display("FAIL fpp_status got %h exp %h", v, 32'h0010_0002);
      end
      rd(3'd1, v);
      checks++;
      if (v !== 32'h0001_00A5) begin
         errors++;
         $display("FAIL fpp_head got %h exp %h", v, 32'h0001_00A5);
      end
      repeat (15) wr(3'd3, 32'h0);
      rd(3'd1, v);
      checks++;
      if (v !== 32'h0019_00A5) begin
         errors++;
         $display("FAIL fpp_tail got %h exp %h", v, 32'h0019_00A5);
      end
      wr(3'd3, 32'h0);
   endtask

   task automatic test_boundaries;
      logic [31:0] v;
      logic [15:0] exp_ts;
      wr(3'd1, 32'h4);
      wr(3'd3, 32'h0);
      rd(3'd0, v);
      checks++;
      if (v !== 32'h0000_0001) begin
         errors++;
         $display("FAIL pop_empty got %h exp %h", v, 32'h1);
      end
      wr(3'd2, 32'd0);
      wr(3'd1, 32'h1);
      wr(3'd1, 32'h5);
      wr(3'd1, 32'h4);
      rd(3'd0, v);
      checks++;
      if (v !== 32'h0000_0001) begin
         errors++;
         $display("FAIL clear_vs_push got %h exp %h", v, 32'h1);
      end
      wr(3'd1, 32'h7);
      repeat (65531) @(negedge clk);
      wr(3'd1, 32'h1);
      repeat (4) @(negedge clk);
      wr(3'd1, 32'h0);
      rd(3'd0, v);
      checks++;
      if (v !== 32'h0005_0000) begin
         errors++;
         $display("FAIL wrap_count got %h exp %h", v, 32'h0005_0000);
      end
      for (int i = 0; i < 5; i++) begin
         exp_ts = 16'hFFFC + 16'(i);
         rd(3'd1, v);
         checks++;
         if (v[31:16] !== exp_ts) begin
            errors++;
            $display("FAIL wrap_ts%0d got %h exp %h", i, v[31:16], exp_ts);
         end
         wr(3'd3, 32'h0);
      end
      wr(3'd2, 32'd0);
      wr(3'd1, 32'h1);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      rd(3'd0, v);
      checks++;
      if (v !== 32'h0000_0001) begin
         errors++;
         $display("FAIL midrun_reset got %h exp %h", v, 32'h1);
      end
      repeat (3) @(negedge clk);
      rd(3'd0, v);
      checks++;
      if (v !== 32'h0000_0001) begin
         errors++;
         $display("FAIL reset_disabled got %h exp %h", v, 32'h1);
      end
`ifdef LOGGER_IRQ_EN
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL reset_irq got %b exp 0", irq);
      end
`endif
   endtask

`ifdef LOGGER_IRQ_EN
   task automatic test_irq;
      logic [31:0] v;
      wr(3'd4, 32'd4);
      rd(3'd4, v);
      checks++;
      if (v !== 32'd4) begin
         errors++;
         $display("FAIL thresh_rb got %h exp %h", v, 32'd4);
      end
      wr(3'd2, 32'd0);
      wr(3'd1, 32'h5);
      repeat (3) @(negedge clk);
      wr(3'd1, 32'h0);
      rd(3'd0, v);
      checks++;
      if (v !== 32'h0004_0000 || irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_lag got %h/%b exp %h/0", v, irq, 32'h0004_0000);
      end
      @(negedge clk);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL irq_rise got %b exp 1", irq);
      end
      wr(3'd3, 32'h0);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL irq_hold got %b exp 1", irq);
      end
      @(negedge clk);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_fall got %b exp 0", irq);
      end
   endtask
`else
   task automatic test_no_thresh;
      logic [31:0] v;
      wr(3'd4, 32'hF);
      rd(3'd4, v);
      checks++;
      if (v !== 32'h0) begin
         errors++;
         $display("FAIL addr4_read got %h exp %h", v, 32'h0);
      end
   endtask
`endif

   initial begin
      checks  = 0;
      errors  = 0;
      reset   = 1'b1;
      cs      = 1'b0;
      read    = 1'b0;
      write   = 1'b0;
      addr    = '0;
      wr_data = '0;
      din     = 8'h00;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      test_reset();
      test_periodic();
      test_on_change();
      test_overflow();
      test_full_push_pop();
      test_boundaries();
`ifdef LOGGER_IRQ_EN
      test_irq();
`else
      test_no_thresh();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
